bsg_manycore_host_mmio_responder: RTL and testbench
===================================================

Name: bsg_manycore_host_mmio_responder

Overview:
- Synthesizable responder at the host coordinate of the manycore network.
- Services tile-initiated requests addressed to the host: finish, fail, print_stat, putchar, cycle-counter reads and scratch registers.
- Returns one response per request.
- Queues host-visible events (finish/fail/print_stat/putchar) in a FIFO that the DPI host drains.
- Attaches behind an endpoint that has already unpacked request packets into fields.

Parameters:
- addr_width_p, 28, EPA word-address width.
- data_width_p, 32, data width; must be 32.
- x_cord_width_p, 7, x coordinate width.
- y_cord_width_p, 7, y coordinate width.
- evt_fifo_els_p, 4, event FIFO depth; power of 2, ≥2.
- num_scratch_p, 8, scratch register count; ≤8.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- in_v_i  in  1  request valid
- in_yumi_o  out  1  request consumed this cycle
- in_we_i  in  1  1=store, 0=load
- in_addr_i  in  addr_width_p  word address
- in_data_i  in  32  store data
- in_mask_i  in  4  byte mask (stores)
- in_src_x_i  in  x_cord_width_p  requester x
- in_src_y_i  in  y_cord_width_p  requester y
- in_reg_id_i  in  5  requester reg id
- resp_v_o  out  1  response valid
- resp_ready_i  in  1  response accept
- resp_load_o  out  1  1=load data, 0=write ack
- resp_data_o  out  32  load data (0 for acks)
- resp_reg_id_o  out  5  echoed reg id
- resp_dst_x_o  out  x_cord_width_p  echoed src x
- resp_dst_y_o  out  y_cord_width_p  echoed src y
- evt_v_o  out  1  event FIFO head valid
- evt_yumi_i  in  1  host dequeues the event
- evt_type_o  out  2  0=finish, 1=fail, 2=print_stat, 3=putchar
- evt_data_o  out  32  store data
- evt_src_x_o  out  x_cord_width_p  event source x
- evt_src_y_o  out  y_cord_width_p  event source y
- err_o  out  1  sticky unmapped-access flag

Behaviour:
Reset and counter:
- All outputs are 0 after reset: resp_v_o, evt_v_o, err_o, in_yumi_o.
- Scratch registers, cycle counter and FIFO pointers clear on reset.
- The 64-bit cycle counter increments every non-reset cycle and wraps at 2^64-1 to 0.

Address map (word addresses):
- 0x0 finish (W)
- 0x1 fail (W)
- 0x2 print_stat (W)
- 0x3 putchar (W)
- 0x4 cycle_lo (R)
- 0x5 cycle_hi (R)
- 0x8..0x8+num_scratch_p-1 scratch (R/W)

Access rules:
- Loads to write-only addresses return 0.
- Stores to read-only addresses are acked without effect.
- Scratch writes honour in_mask_i per byte.
- An access outside the map, or any address bit above bit 3 set, sets err_o, returns 0 / acks, and has no other effect.

State machine (IDLE, RESP):
- IDLE: in_yumi_o=1 when in_v_i and not (request is an event store and FIFO full).
  - On yumi: perform the side effect and capture the response into an output register.
  - Go to RESP.
- RESP: resp_v_o=1 and fields are held stable.
  - On resp_ready_i, return to IDLE. The response is registered, so there is no yumi-to-resp combinational path.
- Minimum latency: request accepted at cycle N, resp_v_o at N+1, next yumi at N+2 at the earliest.
- Throughput: at most one request per 2 cycles.

Read timing:
- cycle_lo and cycle_hi are sampled in the yumi cycle.
- Reading cycle_lo snapshots cycle_hi into a shadow register. A following cycle_hi read returns the shadow, giving atomic 64-bit reads.
- A cycle_hi read with no prior lo read returns the shadow value, which is 0 after reset.

Event FIFO:
- Event store enqueues {type, data, src} in the yumi cycle.
- Full: the request stalls in IDLE (no yumi) until a slot frees.
- Simultaneous evt_yumi_i and enqueue when full: still stalls; the decision uses the registered full flag.
- Simultaneous dequeue and enqueue when non-empty and not full: both happen; count is unchanged.
- evt_v_o is the registered not-empty flag.

Reset mid-operation:
- A pending response and all queued events are discarded.
- err_o clears.

Decomposition:
- Package bsg_manycore_host_mmio_pkg holds:
  - the address-map localparams;
  - an evt_type_e enum (finish, fail, print_stat, putchar);
  - a state enum;
  - an evt_s struct {type, data, src_x, src_y}.
- Sub-module: the event queue is a bsg_fifo_1r1w_small instance (els=evt_fifo_els_p, width=$bits(evt_s)).
- Decode, the FSM and the counter stay in the top module.

Test Plan:
1. Load from 0x8 after reset -> resp_load_o=1, resp_data_o=0; echoed reg_id=5, x=3, y=2 match the request.
2. Store 0xAABBCCDD with mask 4'b0101 to 0x9, then load 0x9 -> data 0x00BB00DD; the store returns an ack with resp_load_o=0.
3. Hold the counter at 0x0000_0001_FFFF_FFFF, load 0x4 then 0x5 -> 0xFFFFFFFF then 0x00000001 even though the counter wrapped between the two reads.
4. Five putchar stores (data 0x41..0x45) with evt_yumi_i=0 and depth 4 -> four acks; the fifth stalls with in_yumi_o=0. One evt_yumi_i -> the fifth is accepted next cycle; evt_data_o drains in order 0x41..0x45.
5. Load 0x100 -> data 0, err_o=1 and stays 1; reset_i pulse -> err_o=0.
6. resp_ready_i=0 for 10 cycles with in_v_i held -> resp_v_o is held with stable fields and no new yumi. Assert reset mid-hold -> resp_v_o=0 the next cycle and the FIFO is empty.

Source files
------------

// File: rtl/bsg_manycore_host_mmio_pkg.sv
// Address map, event types and FSM states shared by the host MMIO responder.
package bsg_manycore_host_mmio_pkg;

    localparam logic [3:0] addr_finish_gp       = 4'h0;
    localparam logic [3:0] addr_fail_gp         = 4'h1;
    localparam logic [3:0] addr_print_stat_gp   = 4'h2;
    localparam logic [3:0] addr_putchar_gp      = 4'h3;
    localparam logic [3:0] addr_cycle_lo_gp     = 4'h4;
    localparam logic [3:0] addr_cycle_hi_gp     = 4'h5;
    localparam logic [3:0] addr_scratch_base_gp = 4'h8;

    localparam int x_cord_width_gp = 7;
    localparam int y_cord_width_gp = 7;

    typedef enum logic [1:0] {
        e_evt_finish,
        e_evt_fail,
        e_evt_print_stat,
        e_evt_putchar
    } evt_type_e;

    typedef enum logic {
        e_idle,
        e_resp
    } state_e;

    typedef struct packed {
        evt_type_e                   evt_type;
        logic [31:0]                 data;
        logic [x_cord_width_gp-1:0]  src_x;
        logic [y_cord_width_gp-1:0]  src_y;
    } evt_s;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO with registered full and not-empty flags.
module bsg_fifo_1r1w_small #(
    parameter int els_p   = 4,
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = $clog2(els_p);

    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp:0]   cnt_q, cnt_d;
    logic                full_q, full_d;
    logic                nempty_q, nempty_d;
    logic                enq, deq;
    logic [width_p-1:0]  mem_q [els_p];

    assign enq     = v_i & ~full_q;
    assign deq     = yumi_i & nempty_q;
    assign ready_o = ~full_q;
    assign v_o     = nempty_q;
    assign data_o  = mem_q[rptr_q];

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        wptr_d   = wptr_q + ptr_w_lp'(enq);
        rptr_d   = rptr_q + ptr_w_lp'(deq);
        cnt_d    = cnt_q + (ptr_w_lp+1)'(enq) - (ptr_w_lp+1)'(deq);
        full_d   = (cnt_d == (ptr_w_lp+1)'(els_p));
        nempty_d = (cnt_d != '0);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            nempty_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            nempty_q <= nempty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bsg_manycore_host_mmio_responder.sv
// Host-coordinate MMIO responder: decodes tile requests, keeps the cycle
// counter and scratch registers, and queues host-visible events.
module bsg_manycore_host_mmio_responder
    import bsg_manycore_host_mmio_pkg::*;
#(
    parameter int addr_width_p   = 28,
    parameter int data_width_p   = 32,
    parameter int x_cord_width_p = x_cord_width_gp,
    parameter int y_cord_width_p = y_cord_width_gp,
    parameter int evt_fifo_els_p = 4,
    parameter int num_scratch_p  = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      in_v_i,
    output logic                      in_yumi_o,
    input  logic                      in_we_i,
    input  logic [addr_width_p-1:0]   in_addr_i,
    input  logic [data_width_p-1:0]   in_data_i,
    input  logic [3:0]                in_mask_i,
    input  logic [x_cord_width_p-1:0] in_src_x_i,
    input  logic [y_cord_width_p-1:0] in_src_y_i,
    input  logic [4:0]                in_reg_id_i,
    output logic                      resp_v_o,
    input  logic                      resp_ready_i,
    output logic                      resp_load_o,
    output logic [data_width_p-1:0]   resp_data_o,
    output logic [4:0]                resp_reg_id_o,
    output logic [x_cord_width_p-1:0] resp_dst_x_o,
    output logic [y_cord_width_p-1:0] resp_dst_y_o,
    output logic                      evt_v_o,
    input  logic                      evt_yumi_i,
    output logic [1:0]                evt_type_o,
    output logic [data_width_p-1:0]   evt_data_o,
    output logic [x_cord_width_p-1:0] evt_src_x_o,
    output logic [y_cord_width_p-1:0] evt_src_y_o,
    output logic                      err_o
);

    state_e state_q, state_d;

    logic [63:0] cycle_q, cycle_d;
    logic [31:0] shadow_q, shadow_d;
    logic        err_q, err_d;
    logic [31:0] scratch_q [8];
    logic [31:0] scratch_d [8];

    logic                      resp_load_q, resp_load_d;
    logic [31:0]               resp_data_q, resp_data_d;
    logic [4:0]                resp_reg_id_q, resp_reg_id_d;
    logic [x_cord_width_p-1:0] resp_x_q, resp_x_d;
    logic [y_cord_width_p-1:0] resp_y_q, resp_y_d;

    logic       addr_hi;
    logic [3:0] lo;
    logic [2:0] scr_idx;
    logic       is_evt_addr, is_cyc_lo, is_cyc_hi, is_scr, is_mapped;
    logic       is_evt_store;
    logic       yumi;
    logic       evt_enq, evt_ready;
    evt_s       evt_in, evt_out;

    assign addr_hi     = |in_addr_i[addr_width_p-1:4];
    assign lo          = in_addr_i[3:0];
    assign scr_idx     = lo[2:0];
    assign is_evt_addr = ~addr_hi & (lo <= addr_putchar_gp);
    assign is_cyc_lo   = ~addr_hi & (lo == addr_cycle_lo_gp);
    assign is_cyc_hi   = ~addr_hi & (lo == addr_cycle_hi_gp);
    assign is_scr      = ~addr_hi & (lo >= addr_scratch_base_gp)
                       & ({1'b0, scr_idx} < 4'(num_scratch_p));
    assign is_mapped   = is_evt_addr | is_cyc_lo | is_cyc_hi | is_scr;
    assign is_evt_store = in_we_i & is_evt_addr;

    always_comb begin
        state_d       = state_q;
        cycle_d       = cycle_q + 64'd1;
        shadow_d      = shadow_q;
        err_d         = err_q;
        scratch_d     = scratch_q;
        resp_load_d   = resp_load_q;
        resp_data_d   = resp_data_q;
        resp_reg_id_d = resp_reg_id_q;
        resp_x_d      = resp_x_q;
        resp_y_d      = resp_y_q;
        yumi          = 1'b0;

        unique case (state_q)
            e_idle: begin
                // Full flag is registered, so a same-cycle dequeue does not help.
                yumi = ~reset_i & in_v_i & ~(is_evt_store & ~evt_ready);
                if (yumi) begin
                    state_d       = e_resp;
                    resp_load_d   = ~in_we_i;
                    resp_data_d   = '0;
                    resp_reg_id_d = in_reg_id_i;
                    resp_x_d      = in_src_x_i;
                    resp_y_d      = in_src_y_i;
                    if (!is_mapped) err_d = 1'b1;
                    unique case (1'b1)
                        (is_cyc_lo & ~in_we_i): begin
                            resp_data_d = cycle_q[31:0];
                            shadow_d    = cycle_q[63:32];
                        end
                        (is_cyc_hi & ~in_we_i): resp_data_d = shadow_q;
                        (is_scr & ~in_we_i): resp_data_d = scratch_q[scr_idx];
                        (is_scr & in_we_i): begin
                            for (int b = 0; b < 4; b++) begin
                                if (in_mask_i[b]) begin
                                    scratch_d[scr_idx][8*b +: 8] = in_data_i[8*b +: 8];
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            e_resp: begin
                if (resp_ready_i) state_d = e_idle;
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= e_idle;
            cycle_q       <= '0;
            shadow_q      <= '0;
            err_q         <= 1'b0;
            scratch_q     <= '{default: '0};
            resp_load_q   <= 1'b0;
            resp_data_q   <= '0;
            resp_reg_id_q <= '0;
            resp_x_q      <= '0;
            resp_y_q      <= '0;
        end else begin
            state_q       <= state_d;
            cycle_q       <= cycle_d;
            shadow_q      <= shadow_d;
            err_q         <= err_d;
            scratch_q     <= scratch_d;
            resp_load_q   <= resp_load_d;
            resp_data_q   <= resp_data_d;
            resp_reg_id_q <= resp_reg_id_d;
            resp_x_q      <= resp_x_d;
            resp_y_q      <= resp_y_d;
        end
    end

    assign evt_enq         = yumi & is_evt_store;
    assign evt_in.evt_type = evt_type_e'(lo[1:0]);
    assign evt_in.data     = in_data_i;
    assign evt_in.src_x    = in_src_x_i;
    assign evt_in.src_y    = in_src_y_i;

    bsg_fifo_1r1w_small #(
        .els_p   (evt_fifo_els_p),
        .width_p ($bits(evt_s))
    ) evt_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (evt_enq),
        .ready_o (evt_ready),
        .data_i  (evt_in),
        .v_o     (evt_v_o),
        .data_o  (evt_out),
        .yumi_i  (evt_yumi_i)
    );

    assign in_yumi_o     = yumi;
    assign resp_v_o      = (state_q == e_resp);
    assign resp_load_o   = resp_load_q;
    assign resp_data_o   = resp_data_q;
    assign resp_reg_id_o = resp_reg_id_q;
    assign resp_dst_x_o  = resp_x_q;
    assign resp_dst_y_o  = resp_y_q;
    assign evt_type_o    = evt_out.evt_type;
    assign evt_data_o    = evt_out.data;
    assign evt_src_x_o   = evt_out.src_x;
    assign evt_src_y_o   = evt_out.src_y;
    assign err_o         = err_q;

endmodule

// File: tb/tb_bsg_manycore_host_mmio_responder.sv
// Bench for the host MMIO responder: transaction-level model plus directed cases.
module tb_bsg_manycore_host_mmio_responder;

    localparam int AW    = 28;
    localparam int DEPTH = 4;
    localparam int NS    = 8;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        in_v_i, in_yumi_o, in_we_i;
    logic [27:0] in_addr_i;
    logic [31:0] in_data_i;
    logic [3:0]  in_mask_i;
    logic [6:0]  in_src_x_i, in_src_y_i;
    logic [4:0]  in_reg_id_i;
    logic        resp_v_o, resp_ready_i, resp_load_o;
    logic [31:0] resp_data_o;
    logic [4:0]  resp_reg_id_o;
    logic [6:0]  resp_dst_x_o, resp_dst_y_o;
    logic        evt_v_o, evt_yumi_i;
    logic [1:0]  evt_type_o;
    logic [31:0] evt_data_o;
    logic [6:0]  evt_src_x_o, evt_src_y_o;
    logic        err_o;

    always #5 clk = ~clk;

    bsg_manycore_host_mmio_responder #(
        .addr_width_p(AW), .data_width_p(32), .x_cord_width_p(7),
        .y_cord_width_p(7), .evt_fifo_els_p(DEPTH), .num_scratch_p(NS)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .in_v_i(in_v_i), .in_yumi_o(in_yumi_o), .in_we_i(in_we_i),
        .in_addr_i(in_addr_i), .in_data_i(in_data_i), .in_mask_i(in_mask_i),
        .in_src_x_i(in_src_x_i), .in_src_y_i(in_src_y_i),
        .in_reg_id_i(in_reg_id_i),
        .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i),
        .resp_load_o(resp_load_o), .resp_data_o(resp_data_o),
        .resp_reg_id_o(resp_reg_id_o), .resp_dst_x_o(resp_dst_x_o),
        .resp_dst_y_o(resp_dst_y_o),
        .evt_v_o(evt_v_o), .evt_yumi_i(evt_yumi_i), .evt_type_o(evt_type_o),
        .evt_data_o(evt_data_o), .evt_src_x_o(evt_src_x_o),
        .evt_src_y_o(evt_src_y_o), .err_o(err_o)
    );

    typedef struct {
        logic [1:0]  t;
        logic [31:0] d;
        logic [6:0]  x;
        logic [6:0]  y;
    } mev_t;

    mev_t        evq[$];
    bit          m_live = 0;
    bit          m_pend, m_load, m_err;
    logic [31:0] m_data, m_shadow;
    logic [4:0]  m_reg;
    logic [6:0]  m_x, m_y;
    logic [63:0] m_cnt;
    logic [31:0] m_scr[NS];

    int n_chk  = 0;
    int n_fail = 0;

    logic        r_load;
    logic [31:0] r_data;
    logic [4:0]  r_reg;
    logic [6:0]  r_x, r_y;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_yumi();
        bit evt_st;
        evt_st = in_we_i && (in_addr_i < 4);
        return !reset_i && in_v_i && !m_pend && !(evt_st && evq.size() == DEPTH);
    endfunction

    function automatic void service();
        int a;
        a      = int'(in_addr_i);
        m_pend = 1;
        m_load = !in_we_i;
        m_data = 0;
        m_reg  = in_reg_id_i;
        m_x    = in_src_x_i;
        m_y    = in_src_y_i;
        if (a > 15 || a == 6 || a == 7 || a >= 8 + NS) begin
            m_err = 1;
        end else if (a < 4) begin
            if (in_we_i) evq.push_back('{in_addr_i[1:0], in_data_i, in_src_x_i, in_src_y_i});
        end else if (a == 4) begin
            if (!in_we_i) begin
                m_data   = m_cnt[31:0];
                m_shadow = m_cnt[63:32];
            end
        end else if (a == 5) begin
            if (!in_we_i) m_data = m_shadow;
        end else if (in_we_i) begin
            for (int b = 0; b < 4; b++)
                if (in_mask_i[b]) m_scr[a-8][8*b +: 8] = in_data_i[8*b +: 8];
        end else begin
            m_data = m_scr[a-8];
        end
    endfunction

    always @(posedge clk) begin
        if (reset_i) begin
            m_live   = 1;
            m_pend   = 0;
            m_err    = 0;
            m_cnt    = 0;
            m_shadow = 0;
            evq.delete();
            for (int i = 0; i < NS; i++) m_scr[i] = 0;
        end else if (m_live) begin
            bit acc, deq;
            acc = exp_yumi();
            deq = evt_yumi_i && evq.size() > 0;
            if (m_pend && resp_ready_i) m_pend = 0;
            if (deq) void'(evq.pop_front());
            if (acc) service();
            m_cnt = m_cnt + 64'd1;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("in_yumi", in_yumi_o, exp_yumi());
            chk("resp_v", resp_v_o, m_pend);
            if (m_pend) begin
                chk("resp_load", resp_load_o, m_load);
                chk("resp_data", resp_data_o, m_data);
                chk("resp_reg", resp_reg_id_o, m_reg);
                chk("resp_x", resp_dst_x_o, m_x);
                chk("resp_y", resp_dst_y_o, m_y);
            end
            chk("evt_v", evt_v_o, evq.size() != 0);
            if (evq.size() != 0) begin
                chk("evt_type", evt_type_o, evq[0].t);
                chk("evt_data", evt_data_o, evq[0].d);
                chk("evt_x", evt_src_x_o, evq[0].x);
                chk("evt_y", evt_src_y_o, evq[0].y);
            end
            chk("err", err_o, m_err);
        end
    end

    // Issue one request and collect its response; starts and ends at posedge+1.
    task automatic req(input logic we, input logic [27:0] addr,
                       input logic [31:0] data, input logic [3:0] mask,
                       input logic [4:0] rid, input logic [6:0] x,
                       input logic [6:0] y);
        int k;
        in_v_i = 1; in_we_i = we; in_addr_i = addr; in_data_i = data;
        in_mask_i = mask; in_reg_id_i = rid; in_src_x_i = x; in_src_y_i = y;
        k = 0;
        @(negedge clk);
        while (!in_yumi_o && k < 50) begin k++; @(negedge clk); end
        if (k >= 50) chk("yumi_timeout", 0, 1);
        @(posedge clk); #1 in_v_i = 0;
        k = 0;
        @(negedge clk);
        while (!resp_v_o && k < 50) begin k++; @(negedge clk); end
        if (k >= 50) chk("resp_timeout", 0, 1);
        r_load = resp_load_o; r_data = resp_data_o; r_reg = resp_reg_id_o;
        r_x = resp_dst_x_o; r_y = resp_dst_y_o;
        @(posedge clk); #1;
    endtask

    task automatic step(); @(posedge clk); #1; endtask

    initial begin
        logic [31:0] h_data;
        logic [4:0]  h_reg;
        reset_i = 1; in_v_i = 0; in_we_i = 0; in_addr_i = 0; in_data_i = 0;
        in_mask_i = 0; in_src_x_i = 0; in_src_y_i = 0; in_reg_id_i = 0;
        resp_ready_i = 1; evt_yumi_i = 0;
        repeat (3) step();
        @(negedge clk);
        chk("reset_resp_v", resp_v_o, 0);
        chk("reset_evt_v", evt_v_o, 0);
        chk("reset_err", err_o, 0);
        chk("reset_yumi", in_yumi_o, 0);
        step();
        reset_i = 0;
        step();

        req(0, 28'h8, 0, 0, 5, 3, 2);
        chk("t1_load", r_load, 1);
        chk("t1_data", r_data, 0);
        chk("t1_reg", r_reg, 5);
        chk("t1_x", r_x, 3);
        chk("t1_y", r_y, 2);

        req(1, 28'h9, 32'hAABBCCDD, 4'b0101, 1, 1, 1);
        chk("t2_ack", r_load, 0);
        req(0, 28'h9, 0, 0, 2, 1, 1);
        chk("t2_data", r_data, 32'h00BB00DD);

        dut.cycle_q = 64'h1_FFFF_FFFF;
        m_cnt = 64'h1_FFFF_FFFF;
        req(0, 28'h4, 0, 0, 3, 0, 0);
        chk("t3_lo", r_data, 32'hFFFFFFFF);
        req(0, 28'h5, 0, 0, 4, 0, 0);
        chk("t3_hi", r_data, 32'h00000001);

        for (int i = 0; i < 4; i++) begin
            req(1, 28'h3, 32'h41 + i, 4'hF, 6, 4, 5);
            chk("t4_ack", r_load, 0);
        end
        in_v_i = 1; in_we_i = 1; in_addr_i = 28'h3; in_data_i = 32'h45;
        repeat (3) begin
            @(negedge clk);
            chk("t4_stall", in_yumi_o, 0);
        end
        chk("t4_head", evt_data_o, 32'h41);
        @(posedge clk); #1 evt_yumi_i = 1;
        @(posedge clk); #1 evt_yumi_i = 0;
        @(negedge clk);
        chk("t4_accept", in_yumi_o, 1);
        @(posedge clk); #1 in_v_i = 0;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk("t4_drain", evt_data_o, 32'h41 + i);
            @(posedge clk); #1 evt_yumi_i = 1;
            @(posedge clk); #1 evt_yumi_i = 0;
        end
        @(negedge clk);
        chk("t4_empty", evt_v_o, 0);
        step();

        req(0, 28'h100, 0, 0, 7, 0, 0);
        chk("t5_data", r_data, 0);
        repeat (3) step();
        @(negedge clk);
        chk("t5_err", err_o, 1);
        step();
        reset_i = 1;
        step();
        reset_i = 0;
        @(negedge clk);
        chk("t5_err_clr", err_o, 0);
        step();

        req(1, 28'h2, 32'h1234, 4'hF, 0, 2, 2);
        resp_ready_i = 0;
        in_v_i = 1; in_we_i = 0; in_addr_i = 28'h8; in_reg_id_i = 9;
        in_src_x_i = 1; in_src_y_i = 6;
        @(negedge clk);
        chk("t6_first_yumi", in_yumi_o, 1);
        @(posedge clk); #1 in_addr_i = 28'h9;
        @(negedge clk);
        h_data = resp_data_o; h_reg = resp_reg_id_o;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_hold_v", resp_v_o, 1);
            chk("t6_hold_reg", resp_reg_id_o, h_reg);
            chk("t6_hold_data", resp_data_o, h_data);
            chk("t6_no_yumi", in_yumi_o, 0);
        end
        step();
        reset_i = 1; in_v_i = 0;
        step();
        reset_i = 0; resp_ready_i = 1;
        @(negedge clk);
        chk("t6_resp_drop", resp_v_o, 0);
        chk("t6_fifo_drop", evt_v_o, 0);
        step();

        repeat (4000) begin
            step();
            reset_i      = ($urandom_range(0, 299) == 0);
            in_v_i       = 1'($urandom_range(0, 1));
            in_we_i      = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       in_addr_i = 28'($urandom);
                1:       in_addr_i = 28'($urandom_range(6, 7));
                default: in_addr_i = 28'($urandom_range(0, 15));
            endcase
            in_data_i    = $urandom;
            in_mask_i    = 4'($urandom);
            in_reg_id_i  = 5'($urandom);
            in_src_x_i   = 7'($urandom);
            in_src_y_i   = 7'($urandom);
            resp_ready_i = ($urandom_range(0, 3) != 0);
            evt_yumi_i   = ($urandom_range(0, 2) == 0);
        end
        step();
        reset_i = 0; in_v_i = 0; evt_yumi_i = 0; resp_ready_i = 1;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
